// File: rtl/mult_pkg.sv
// Shared types and widths for the multiply-accumulate datapath.
package mult_pkg;

    localparam int unsigned PROD_W = 8;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } macc_state_t;

endpackage

// File: rtl/mult_accum_if.sv
// Product input and group-result output handshakes of the accumulator.
interface mult_accum_if #(
    parameter int unsigned ACC_W = 10
);
    import mult_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] prod;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  sum;
    logic [CNT_W-1:0]  cnt;
    logic              ovf;

    // Accumulator side.
    modport slave (
        input  in_valid, prod, in_last, out_ready,
        output in_ready, out_valid, sum, cnt, ovf
    );

    // Producer/consumer side.
    modport master (
        output in_valid, prod, in_last, out_ready,
        input  in_ready, out_valid, sum, cnt, ovf
    );

endinterface

// File: rtl/mult_accum_beat_counter.sv
// Counts products in the open group; flags when the next beat completes LEN.
module beat_counter
    import mult_pkg::*;
#(
    parameter int unsigned LEN = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_one,
    input  logic             incr,
    output logic [CNT_W-1:0] cnt,
    output logic             terminal
);

    localparam int unsigned EXT_W = CNT_W + 1;

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    // Next count: a group's first beat restarts at one, later beats add one.
    always_comb begin
        cnt_d = cnt_q;
        if (load_one) begin
            cnt_d = CNT_W'(1);
        end else if (incr) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt      = cnt_q;
    assign terminal = ({1'b0, cnt_q} + EXT_W'(1)) == EXT_W'(LEN);

endmodule

// File: rtl/mult_accum.sv
// Sums groups of up to LEN multiplier products and holds each group result
// until the consumer takes it.
module mult_accum
    import mult_pkg::*;
#(
    parameter int unsigned LEN   = 4,
    parameter int unsigned ACC_W = 10
) (
    input  logic         clk,
    input  logic         rst,
    mult_accum_if.slave  bus
);

    macc_state_t      state_d, state_q;
    logic [ACC_W-1:0] acc_d, acc_q;
    logic             ovf_d, ovf_q;
    logic             out_valid_d, out_valid_q;

    logic             in_ready_c;
    logic             acc_fire;
    logic             out_fire;
    logic             first_beat;
    logic             next_beat;
    logic             terminal;
    logic [CNT_W-1:0] cnt;
    logic [ACC_W:0]   sum_ext;

    // A held result blocks new beats unless it is taken in the same cycle.
    assign in_ready_c = (state_q != HOLD) || bus.out_ready;
    assign acc_fire   = bus.in_valid && in_ready_c;
    assign out_fire   = out_valid_q && bus.out_ready;
    assign first_beat = acc_fire && (state_q != ACC);
    assign next_beat  = acc_fire && (state_q == ACC);
    assign sum_ext    = {1'b0, acc_q} + (ACC_W + 1)'(bus.prod);

    beat_counter #(
        .LEN(LEN)
    ) u_beat_counter (
        .clk     (clk),
        .rst     (rst),
        .load_one(first_beat),
        .incr    (next_beat),
        .cnt     (cnt),
        .terminal(terminal)
    );

    // Next-state and accumulator update.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE, HOLD: begin
                if (first_beat) begin
                    acc_d   = ACC_W'(bus.prod);
                    ovf_d   = 1'b0;
                    state_d = ((LEN == 1) || bus.in_last) ? HOLD : ACC;
                end else if ((state_q == HOLD) && out_fire) begin
                    state_d = IDLE;
                end
            end
            ACC: begin
                if (next_beat) begin
                    acc_d   = sum_ext[ACC_W-1:0];
                    ovf_d   = ovf_q | sum_ext[ACC_W];
                    state_d = (terminal || bus.in_last) ? HOLD : ACC;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        out_valid_d = (state_d == HOLD);
    end

    // State and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = acc_q;
    assign bus.cnt       = cnt;
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_mult_accum.sv
// Drives three accumulator configurations with shared stimulus and checks
// each against a group-level reference model.
module tb_mult_accum;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] prod;
    logic       in_last;
    logic       out_ready;

    int n_checks;
    int n_fail;

    mult_accum_if #(.ACC_W(10)) if0 ();
    mult_accum_if #(.ACC_W(9))  if9 ();
    mult_accum_if #(.ACC_W(10)) if1 ();

    assign if0.in_valid = in_valid;  assign if0.prod = prod;
    assign if0.in_last  = in_last;   assign if0.out_ready = out_ready;
    assign if9.in_valid = in_valid;  assign if9.prod = prod;
    assign if9.in_last  = in_last;   assign if9.out_ready = out_ready;
    assign if1.in_valid = in_valid;  assign if1.prod = prod;
    assign if1.in_last  = in_last;   assign if1.out_ready = out_ready;

    mult_accum #(.LEN(4), .ACC_W(10)) u_dut  (.clk(clk), .rst(rst), .bus(if0));
    mult_accum #(.LEN(4), .ACC_W(9))  u_dut9 (.clk(clk), .rst(rst), .bus(if9));
    mult_accum #(.LEN(1), .ACC_W(10)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));

    logic       o_ready [3];
    logic       o_valid [3];
    logic [9:0] o_sum   [3];
    logic [3:0] o_cnt   [3];
    logic       o_ovf   [3];

    assign o_ready[0] = if0.in_ready;  assign o_ready[1] = if9.in_ready;  assign o_ready[2] = if1.in_ready;
    assign o_valid[0] = if0.out_valid; assign o_valid[1] = if9.out_valid; assign o_valid[2] = if1.out_valid;
    assign o_sum[0]   = if0.sum;       assign o_sum[1]   = {1'b0, if9.sum}; assign o_sum[2] = if1.sum;
    assign o_cnt[0]   = if0.cnt;       assign o_cnt[1]   = if9.cnt;       assign o_cnt[2]   = if1.cnt;
    assign o_ovf[0]   = if0.ovf;       assign o_ovf[1]   = if9.ovf;       assign o_ovf[2]   = if1.ovf;

    // Reference model: per configuration, the open group's true (unwrapped)
    // total and beat count, plus whether a finished result is waiting.
    bit m_hold  [3];
    bit m_open  [3];
    bit m_known [3];
    int m_tot   [3];
    int m_n     [3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int len_of(input int i);
        return (i == 2) ? 1 : 4;
    endfunction

    function automatic int mod_of(input int i);
        return (i == 1) ? 512 : 1024;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_model();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("in_ready[%0d]", i), 32'(o_ready[i]), 32'(!m_hold[i] || out_ready));
            check($sformatf("out_valid[%0d]", i), 32'(o_valid[i]), 32'(m_hold[i]));
            if (m_known[i] || m_open[i] || m_hold[i]) begin
                check($sformatf("sum[%0d]", i), 32'(o_sum[i]), 32'(m_tot[i] % mod_of(i)));
                check($sformatf("cnt[%0d]", i), 32'(o_cnt[i]), 32'(m_n[i]));
                check($sformatf("ovf[%0d]", i), 32'(o_ovf[i]), 32'(m_tot[i] >= mod_of(i)));
            end
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_hold[i] = 1'b0; m_open[i] = 1'b0; m_known[i] = 1'b1;
            m_tot[i]  = 0;    m_n[i]    = 0;
        end
    endtask

    task automatic model_update();
        bit take;
        if (rst) begin
            model_reset();
            return;
        end
        for (int i = 0; i < 3; i++) begin
            take = in_valid && (!m_hold[i] || out_ready);
            if (m_hold[i] && out_ready) begin
                m_hold[i]  = 1'b0;
                m_known[i] = 1'b0;
            end
            if (take) begin
                if (!m_open[i]) begin
                    m_open[i] = 1'b1;
                    m_tot[i]  = int'(prod);
                    m_n[i]    = 1;
                end else begin
                    m_tot[i] += int'(prod);
                    m_n[i]++;
                end
                if (m_n[i] == len_of(i) || in_last) begin
                    m_open[i] = 1'b0;
                    m_hold[i] = 1'b1;
                end
            end
        end
    endtask

    task automatic drive(input bit v, input int p, input bit l, input bit r, input bit rs);
        @(negedge clk);
        in_valid  = v;
        prod      = 8'(p);
        in_last   = l;
        out_ready = r;
        rst       = rs;
        #1;
        check_model();
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
    endtask

    task automatic cyc(input bit v, input int p, input bit l, input bit r, input bit rs);
        drive(v, p, l, r, rs);
        tick();
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        prod      = 8'd0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);

        // Reset values.
        drive(0, 0, 0, 1, 0);
        check("rst_sum", 32'(o_sum[0]), 32'd0);
        check("rst_in_ready", 32'(o_ready[0]), 32'd1);
        tick();

        // Four large products, no overflow at 10 bits.
        repeat (4) cyc(1, 225, 0, 1, 0);
        drive(0, 0, 0, 1, 0);
        check("tp1_valid", 32'(o_valid[0]), 32'd1);
        check("tp1_sum", 32'(o_sum[0]), 32'd900);
        check("tp1_cnt", 32'(o_cnt[0]), 32'd4);
        check("tp1_ovf", 32'(o_ovf[0]), 32'd0);
        tick();

        // Early end with in_last, next group restarts from zero.
        cyc(1, 10, 0, 1, 0);
        cyc(1, 20, 1, 1, 0);
        drive(0, 0, 0, 1, 0);
        check("tp2_sum", 32'(o_sum[0]), 32'd30);
        check("tp2_cnt", 32'(o_cnt[0]), 32'd2);
        tick();
        cyc(1, 5, 1, 1, 0);
        drive(0, 0, 0, 1, 0);
        check("tp2_restart", 32'(o_sum[0]), 32'd5);
        tick();

        // Overflow in the 9-bit configuration.
        cyc(1, 225, 0, 1, 0);
        cyc(1, 225, 0, 1, 0);
        cyc(1, 225, 1, 1, 0);
        drive(0, 0, 0, 1, 0);
        check("tp3_sum9", 32'(o_sum[1]), 32'd163);
        check("tp3_ovf9", 32'(o_ovf[1]), 32'd1);
        check("tp3_cnt9", 32'(o_cnt[1]), 32'd3);
        tick();

        // Back-pressure: held result stays put, raised in_valid not consumed.
        cyc(1, 3, 1, 0, 0);
        repeat (5) begin
            drive(1, 99, 0, 0, 0);
            check("tp4_stall_ready", 32'(o_ready[0]), 32'd0);
            check("tp4_stall_sum", 32'(o_sum[0]), 32'd3);
            tick();
        end
        cyc(1, 7, 0, 1, 0);
        drive(0, 0, 0, 0, 0);
        check("tp4_new_sum", 32'(o_sum[0]), 32'd7);
        check("tp4_new_cnt", 32'(o_cnt[0]), 32'd1);
        tick();
        cyc(1, 0, 1, 1, 0);
        cyc(0, 0, 0, 1, 0);

        // LEN=1: one result per cycle with no bubble.
        cyc(1, 1, 0, 1, 0);
        drive(1, 2, 0, 1, 0);
        check("tp5_r1", 32'(o_sum[2]), 32'd1);
        check("tp5_v1", 32'(o_valid[2]), 32'd1);
        tick();
        drive(1, 3, 1, 1, 0);
        check("tp5_r2", 32'(o_sum[2]), 32'd2);
        check("tp5_v2", 32'(o_valid[2]), 32'd1);
        tick();
        drive(0, 0, 0, 1, 0);
        check("tp5_r3", 32'(o_sum[2]), 32'd3);
        check("tp5_v3", 32'(o_valid[2]), 32'd1);
        tick();

        // Reset mid-group discards the partial sum.
        cyc(1, 4, 0, 1, 0);
        cyc(1, 6, 0, 1, 0);
        cyc(1, 9, 0, 1, 1);
        drive(0, 0, 0, 1, 0);
        check("tp6_valid", 32'(o_valid[0]), 32'd0);
        check("tp6_sum", 32'(o_sum[0]), 32'd0);
        tick();
        cyc(1, 50, 0, 1, 0);
        cyc(1, 60, 0, 1, 0);
        cyc(1, 70, 0, 1, 0);
        cyc(1, 80, 0, 1, 0);
        drive(0, 0, 0, 1, 0);
        check("tp6_fresh_sum", 32'(o_sum[0]), 32'd260);
        check("tp6_fresh_cnt", 32'(o_cnt[0]), 32'd4);
        tick();

        // Randomized traffic with occasional resets.
        for (int k = 0; k < 3000; k++) begin
            cyc(($urandom_range(0, 99) < 70), int'($urandom_range(0, 255)),
                ($urandom_range(0, 99) < 20), ($urandom_range(0, 99) < 65),
                ($urandom_range(0, 199) == 0));
        end
        repeat (3) cyc(0, 0, 0, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
